// File: rtl/regbank_ctrl_n_32.sv
// regbank_ctrl_n_32: two-requester access controller for a 4 x 32-bit register bank
// Optional feature macro: REGBANK_FIXED_PRIO_EN (requester 0 always wins, no last-grant pointer)
module regbank_ctrl_n_32 #(
   parameter int AW = 2,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          hresetn,
   input  logic          req0,
   input  logic          req1,
   input  logic          rw0,
   input  logic          rw1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] sr1,
   output logic [AW-1:0] dr1,
   output logic          read_write,
   output logic [DW-1:0] hrdatax1,
   input  logic [DW-1:0] data_in1x1
);
   typedef enum logic [2:0] {IDLE, WR, RD, CAPT, ACK} state_t;
   state_t        state;
   logic          gid;
   logic          gnt;
   logic          sel_rw;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
`ifndef REGBANK_FIXED_PRIO_EN
   logic          ptr;
`endif
   // choose the requester to grant and mux its request fields
   always_comb begin
`ifdef REGBANK_FIXED_PRIO_EN
      gnt = ~req0;
`else
      gnt = (req0 & req1) ? ~ptr : req1;
`endif
      sel_rw    = gnt ? rw1 : rw0;
      sel_addr  = gnt ? addr1 : addr0;
      sel_wdata = gnt ? wdata1 : wdata0;
   end
   // sequencer: one bank operation at a time, all outputs registered
   always_ff @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         state      <= IDLE;
         gid        <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
         read_write <= 1'b1;
         sr1        <= '0;
         dr1        <= '0;
         hrdatax1   <= '0;
         rdata      <= '0;
`ifndef REGBANK_FIXED_PRIO_EN
         ptr        <= 1'b1;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: if (req0 | req1) begin
               gid  <= gnt;
               busy <= 1'b1;
`ifndef REGBANK_FIXED_PRIO_EN
               ptr  <= gnt;
`endif
               if (sel_rw) begin
                  state <= RD;
                  sr1   <= sel_addr;
               end else begin
                  state      <= WR;
                  read_write <= 1'b0;
                  dr1        <= sel_addr;
                  hrdatax1   <= sel_wdata;
               end
            end
            WR: begin
               read_write <= 1'b1;
               state      <= ACK;
               ack0       <= ~gid;
               ack1       <= gid;
            end
            RD: state <= CAPT;
            CAPT: begin
               rdata <= data_in1x1;
               state <= ACK;
               ack0  <= ~gid;
               ack1  <= gid;
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy       <= 1'b0;
               read_write <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_regbank_ctrl_n_32.sv
// tb_regbank_ctrl_n_32: directed bench for regbank_ctrl_n_32 with a behavioural register bank
module tb_regbank_ctrl_n_32;
   logic        clk = 1'b0;
   logic        hresetn = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
   logic [1:0]  addr0 = 2'd0, addr1 = 2'd0;
   logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0, data_in1x1 = 32'd0;
   logic        ack0, ack1, busy, read_write;
   logic [1:0]  sr1, dr1;
   logic [31:0] rdata, hrdatax1;
   logic [31:0] bank [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
   logic        eid;
   int          checks = 0;
   int          errors = 0;

   regbank_ctrl_n_32 dut (
      .clk(clk), .hresetn(hresetn),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
      .sr1(sr1), .dr1(dr1), .read_write(read_write),
      .hrdatax1(hrdatax1), .data_in1x1(data_in1x1)
   );

   always #5 clk = ~clk;

   // register bank: writes when read_write is 0, registered read of sr1
   always @(posedge clk) begin
      if (!read_write) bank[dr1] <= hrdatax1;
      data_in1x1 <= bank[sr1];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_ack", 32'({ack1, ack0}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_read_write", 32'(read_write), 32'd1);
      chk("rst_sr1", 32'(sr1), 32'd0);
      chk("rst_dr1", 32'(dr1), 32'd0);
      chk("rst_hrdatax1", hrdatax1, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
   endtask

   initial begin
      repeat (2) tick();
      chk_reset();
      hresetn = 1'b1;
      tick();
      req0 = 1'b1; rw0 = 1'b1; addr0 = 2'd3;
      tick();
      chk("abort_rd_busy", 32'(busy), 32'd1);
      chk("abort_rd_sr1", 32'(sr1), 32'd3);
      hresetn = 1'b0;
      #1;
      chk_reset();
      req0 = 1'b0;
      tick();
      hresetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_no_ack", 32'({ack1, ack0}), 32'd0);
         chk("abort_idle_busy", 32'(busy), 32'd0);
      end

      req0 = 1'b1; rw0 = 1'b0; addr0 = 2'd1; wdata0 = 32'h11111111;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 2'd1; wdata1 = 32'h22222222;
      tick();
      chk("sim_wr0_rw", 32'(read_write), 32'd0);
      chk("sim_wr0_dr1", 32'(dr1), 32'd1);
      chk("sim_wr0_data", hrdatax1, 32'h11111111);
      chk("sim_wr0_noack", 32'({ack1, ack0}), 32'd0);
      tick();
      chk("sim_ack0_first", 32'({ack1, ack0}), 32'd1);
      tick();
      req0 = 1'b0;
      chk("sim_idle_busy", 32'(busy), 32'd0);
      tick();
      chk("sim_wr1_rw", 32'(read_write), 32'd0);
      chk("sim_wr1_data", hrdatax1, 32'h22222222);
      tick();
      chk("sim_ack1_second", 32'({ack1, ack0}), 32'd2);
      tick();
      req1 = 1'b0;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 2'd1;
      repeat (3) tick();
      chk("sim_rd_ack", 32'({ack1, ack0}), 32'd1);
      chk("sim_rd_data", rdata, 32'h22222222);
      tick();

      rw0 = 1'b0; addr0 = 2'd2; wdata0 = 32'hDEADBEEF;
      tick();
      chk("wr_rw", 32'(read_write), 32'd0);
      chk("wr_dr1", 32'(dr1), 32'd2);
      chk("wr_busy", 32'(busy), 32'd1);
      tick();
      chk("wr_ack", 32'({ack1, ack0}), 32'd1);
      chk("wr_rw_back", 32'(read_write), 32'd1);
      chk("wr_dr1_hold", 32'(dr1), 32'd2);
      chk("wr_data_hold", hrdatax1, 32'hDEADBEEF);
      chk("wr_rdata_hold", rdata, 32'h22222222);
      tick();
      rw0 = 1'b1;
      tick();
      chk("rd_rw", 32'(read_write), 32'd1);
      chk("rd_sr1", 32'(sr1), 32'd2);
      chk("rd_noack", 32'({ack1, ack0}), 32'd0);
      tick();
      chk("capt_noack", 32'({ack1, ack0}), 32'd0);
      tick();
      chk("rd_ack", 32'({ack1, ack0}), 32'd1);
      chk("rd_data", rdata, 32'hDEADBEEF);
      tick();
      req0 = 1'b0;

      hresetn = 1'b0;
      #1;
      hresetn = 1'b1;
      req0 = 1'b1; rw0 = 1'b1; addr0 = 2'd2;
      req1 = 1'b1; rw1 = 1'b1; addr1 = 2'd1;
      for (int k = 0; k < 8; k++) begin
`ifdef REGBANK_FIXED_PRIO_EN
         eid = 1'b0;
`else
         eid = k[0];
`endif
         tick();
         chk("rr_rd_busy", 32'(busy), 32'd1);
         chk("rr_rd_noack", 32'({ack1, ack0}), 32'd0);
         tick();
         chk("rr_capt_busy", 32'(busy), 32'd1);
         tick();
         chk("rr_ack_busy", 32'(busy), 32'd1);
         chk("rr_ack_id", 32'({ack1, ack0}), eid ? 32'd2 : 32'd1);
         chk("rr_rdata", rdata, eid ? 32'h22222222 : 32'hDEADBEEF);
         tick();
         chk("rr_idle", 32'(busy), 32'd0);
      end
      req0 = 1'b0; req1 = 1'b0;

      for (int i = 0; i < 20; i++) begin
         wdata0 = $urandom; wdata1 = $urandom; rw0 = 1'b0; rw1 = 1'b0;
         tick();
         chk("prot_read_write", 32'(read_write), 32'd1);
      end
      chk("prot_reg1", bank[1], 32'h22222222);
      chk("prot_reg2", bank[2], 32'hDEADBEEF);
      req1 = 1'b1; rw1 = 1'b1; addr1 = 2'd2;
      repeat (3) tick();
      chk("prot_rd_ack", 32'({ack1, ack0}), 32'd2);
      chk("prot_rd_data", rdata, 32'hDEADBEEF);
      tick();
      req1 = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
